// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit count counter width; never narrower than one bit.
  function automatic int unsigned CNT_W(input int unsigned width);
    int unsigned w;
    w = int'($clog2(width));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit combinational full adder slice.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds a 'sub' input).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = CNT_W(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              slice_s, slice_co;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  fa_bit u_fa_bit (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = slice_s;
        carry_d  = slice_co;
        count_d  = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          sum_d   = sum_sh_d;
          cout_d  = slice_co;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule
